// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controller_pkg
//  Description : Shared LA bit map, OEB defaults and override-mux helper for
//                the controller front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
package controller_pkg;

  localparam int LA_RESET_OEB    = 0;
  localparam int LA_LATCH_OEB    = 1;
  localparam int LA_TRIG_OEB     = 2;
  localparam int LA_UCC_OEB      = 3;
  localparam int LA_RESET        = 4;
  localparam int LA_LATCH        = 5;
  localparam int LA_TRIG         = 6;
  localparam int LA_UCC          = 7;
  localparam int LA_DRV_OEB_BASE = 8;

  localparam logic OEB_DEFAULT_RESET = 1'b1;
  localparam logic OEB_DEFAULT_LATCH = 1'b1;
  localparam logic OEB_DEFAULT_TRIG  = 1'b1;
  localparam logic OEB_DEFAULT_UCC   = 1'b0;
  localparam logic OEB_DEFAULT_DRV   = 1'b0;

  // la_oenb is active-low: 0 means the LA value wins.
  function automatic logic la_sel(input logic oenb, input logic la_val, input logic dflt);
    return oenb ? dflt : la_val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_fifo
//  Description : Synchronous show-ahead FIFO with flush, level output and a
//                sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = (r_level != '0) && pop_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = push && (!w_full || w_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LW'(w_push_ok) - LW'(w_pop);
      if (push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  assign valid    = (r_level != '0);
  assign rdata    = valid ? r_mem[r_rd_ptr] : '0;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/controller_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : controller_frontend
//  Description : LA override muxes, synchronised/filtered control inputs and
//                SPI command capture FIFO in front of system_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module controller_frontend
  import controller_pkg::*;
#(
  parameter int NUM_OF_DRIVERS = 10,
  parameter int CMD_WIDTH      = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [8+NUM_OF_DRIVERS-1:0]   la_data_in,
  input  logic [8+NUM_OF_DRIVERS-1:0]   la_oenb,
  input  logic                          io_reset_n_in,
  input  logic                          io_latch_data_in,
  input  logic                          io_control_trigger_in,
  input  logic                          update_cycle_complete,
  input  logic                          spi_data_clock,
  input  logic [CMD_WIDTH-1:0]          spi_data,
  input  logic                          cmd_ready,
  output logic                          io_reset_n_oeb,
  output logic                          io_latch_data_oeb,
  output logic                          io_control_trigger_oeb,
  output logic                          io_update_cycle_complete_oeb,
  output logic                          io_update_cycle_complete_out,
  output logic [NUM_OF_DRIVERS-1:0]     io_driver_io_oeb,
  output logic                          core_reset_n,
  output logic                          latch_data_s,
  output logic                          control_trigger_s,
  output logic                          latch_data_rise,
  output logic [CMD_WIDTH-1:0]          cmd_data,
  output logic                          cmd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_overflow
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic                      r_reset_oeb;
  logic                      r_latch_oeb;
  logic                      r_trig_oeb;
  logic                      r_ucc_oeb;
  logic                      r_ucc_out;
  logic                      r_reset_raw;
  logic                      r_latch_raw;
  logic                      r_trig_raw;
  logic [NUM_OF_DRIVERS-1:0] r_drv_oeb;
  logic [2:0]                r_sync1;
  logic [2:0]                r_sync2;
  logic                      r_spi_s1;
  logic                      r_spi_s2;
  logic                      r_spi_s3;
  logic                      r_core_rst_n;
  logic [CNT_W-1:0]          r_rst_cnt;
  logic                      r_rise;
  logic [1:0]                w_filt_in;
  logic [1:0]                w_filt_out;
  logic [1:0]                w_filt_set;
  logic                      w_capture;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_reset_oeb <= 1'b1;
      r_latch_oeb <= 1'b1;
      r_trig_oeb  <= 1'b1;
      r_ucc_oeb   <= 1'b1;
      r_ucc_out   <= 1'b0;
      r_reset_raw <= 1'b0;
      r_latch_raw <= 1'b0;
      r_trig_raw  <= 1'b0;
    end else begin
      r_reset_oeb <= la_sel(la_oenb[LA_RESET_OEB], la_data_in[LA_RESET_OEB], OEB_DEFAULT_RESET);
      r_latch_oeb <= la_sel(la_oenb[LA_LATCH_OEB], la_data_in[LA_LATCH_OEB], OEB_DEFAULT_LATCH);
      r_trig_oeb  <= la_sel(la_oenb[LA_TRIG_OEB],  la_data_in[LA_TRIG_OEB],  OEB_DEFAULT_TRIG);
      r_ucc_oeb   <= la_sel(la_oenb[LA_UCC_OEB],   la_data_in[LA_UCC_OEB],   OEB_DEFAULT_UCC);
      r_reset_raw <= la_sel(la_oenb[LA_RESET], la_data_in[LA_RESET], io_reset_n_in);
      r_latch_raw <= la_sel(la_oenb[LA_LATCH], la_data_in[LA_LATCH], io_latch_data_in);
      r_trig_raw  <= la_sel(la_oenb[LA_TRIG],  la_data_in[LA_TRIG],  io_control_trigger_in);
      r_ucc_out   <= la_sel(la_oenb[LA_UCC],   la_data_in[LA_UCC],   update_cycle_complete);
    end
  end

  for (genvar g = 0; g < NUM_OF_DRIVERS; g++) begin : g_drv_oeb
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_drv_oeb[g] <= 1'b1;
      else          r_drv_oeb[g] <= la_sel(la_oenb[LA_DRV_OEB_BASE+g],
                                           la_data_in[LA_DRV_OEB_BASE+g], OEB_DEFAULT_DRV);
    end
  end

  // Bit order {trigger, latch, reset}; SPI toggle gets an extra delay stage for edge detect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_spi_s1 <= 1'b0;
      r_spi_s2 <= 1'b0;
      r_spi_s3 <= 1'b0;
    end else begin
      r_sync1  <= {r_trig_raw, r_latch_raw, r_reset_raw};
      r_sync2  <= r_sync1;
      r_spi_s1 <= spi_data_clock;
      r_spi_s2 <= r_spi_s1;
      r_spi_s3 <= r_spi_s2;
    end
  end

  assign w_filt_in = {r_sync2[2], r_sync2[1]};

  // Level flips after FILTER_LEN consecutive samples that disagree with it.
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_flip;

    assign w_flip = (w_filt_in[g] != r_level) && (r_cnt == CNT_W'(FILTER_LEN - 1));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else if (w_filt_in[g] == r_level) begin
        r_cnt   <= '0;
      end else if (w_flip) begin
        r_level <= w_filt_in[g];
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end

    assign w_filt_out[g] = r_level;
    assign w_filt_set[g] = w_flip && w_filt_in[g];
  end

  // Reset is released on the first synchronised 1 but asserted only after a run of 0s.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_core_rst_n <= 1'b0;
      r_rst_cnt    <= '0;
      r_rise       <= 1'b0;
    end else begin
      r_rise <= w_filt_set[0];
      if (r_sync2[0]) begin
        r_core_rst_n <= 1'b1;
        r_rst_cnt    <= '0;
      end else if (!r_core_rst_n) begin
        r_rst_cnt    <= '0;
      end else if (r_rst_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_core_rst_n <= 1'b0;
        r_rst_cnt    <= '0;
      end else begin
        r_rst_cnt    <= r_rst_cnt + 1'b1;
      end
    end
  end

  assign w_capture = r_spi_s2 ^ r_spi_s3;

  cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (!r_core_rst_n),
    .push      (w_capture),
    .wdata     (spi_data),
    .pop_ready (cmd_ready),
    .rdata     (cmd_data),
    .valid     (cmd_valid),
    .level     (fifo_level),
    .overflow  (fifo_overflow)
  );

  assign io_reset_n_oeb               = r_reset_oeb;
  assign io_latch_data_oeb            = r_latch_oeb;
  assign io_control_trigger_oeb       = r_trig_oeb;
  assign io_update_cycle_complete_oeb = r_ucc_oeb;
  assign io_update_cycle_complete_out = r_ucc_out;
  assign io_driver_io_oeb             = r_drv_oeb;
  assign core_reset_n                 = r_core_rst_n;
  assign latch_data_s                 = w_filt_out[0];
  assign control_trigger_s            = w_filt_out[1];
  assign latch_data_rise              = r_rise;

endmodule
`default_nettype wire

// File: tb/tb_controller_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controller_frontend
//  Description : Self-checking bench for controller_frontend with a word
//                scoreboard on the command FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controller_frontend;
  import controller_pkg::*;

  localparam int NUM_OF_DRIVERS = 10;
  localparam int CMD_WIDTH      = 32;
  localparam int FIFO_DEPTH     = 4;
  localparam int FILTER_LEN     = 3;
  localparam int LA_W           = 8 + NUM_OF_DRIVERS;
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic [LA_W-1:0]           la_data_in;
  logic [LA_W-1:0]           la_oenb;
  logic                      io_reset_n_in;
  logic                      io_latch_data_in;
  logic                      io_control_trigger_in;
  logic                      update_cycle_complete;
  logic                      spi_data_clock;
  logic [CMD_WIDTH-1:0]      spi_data;
  logic                      cmd_ready;
  logic                      io_reset_n_oeb;
  logic                      io_latch_data_oeb;
  logic                      io_control_trigger_oeb;
  logic                      io_update_cycle_complete_oeb;
  logic                      io_update_cycle_complete_out;
  logic [NUM_OF_DRIVERS-1:0] io_driver_io_oeb;
  logic                      core_reset_n;
  logic                      latch_data_s;
  logic                      control_trigger_s;
  logic                      latch_data_rise;
  logic [CMD_WIDTH-1:0]      cmd_data;
  logic                      cmd_valid;
  logic [LVL_W-1:0]          fifo_level;
  logic                      fifo_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q [$];

  controller_frontend #(
    .NUM_OF_DRIVERS (NUM_OF_DRIVERS),
    .CMD_WIDTH      (CMD_WIDTH),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .FILTER_LEN     (FILTER_LEN)
  ) dut (
    .clock                        (clock),
    .reset_n                      (reset_n),
    .la_data_in                   (la_data_in),
    .la_oenb                      (la_oenb),
    .io_reset_n_in                (io_reset_n_in),
    .io_latch_data_in             (io_latch_data_in),
    .io_control_trigger_in        (io_control_trigger_in),
    .update_cycle_complete        (update_cycle_complete),
    .spi_data_clock               (spi_data_clock),
    .spi_data                     (spi_data),
    .cmd_ready                    (cmd_ready),
    .io_reset_n_oeb               (io_reset_n_oeb),
    .io_latch_data_oeb            (io_latch_data_oeb),
    .io_control_trigger_oeb       (io_control_trigger_oeb),
    .io_update_cycle_complete_oeb (io_update_cycle_complete_oeb),
    .io_update_cycle_complete_out (io_update_cycle_complete_out),
    .io_driver_io_oeb             (io_driver_io_oeb),
    .core_reset_n                 (core_reset_n),
    .latch_data_s                 (latch_data_s),
    .control_trigger_s            (control_trigger_s),
    .latch_data_rise              (latch_data_rise),
    .cmd_data                     (cmd_data),
    .cmd_valid                    (cmd_valid),
    .fifo_level                   (fifo_level),
    .fifo_overflow                (fifo_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit stored);
    spi_data       = w;
    spi_data_clock = ~spi_data_clock;
    if (stored) sb_q.push_back(w);
    step(5);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    cmd_ready = 1'b1;
    while (sb_q.size() > 0 && n < 20) begin
      if (cmd_valid) check(tag, cmd_data, sb_q.pop_front());
      step(1);
      n++;
    end
    cmd_ready = 1'b0;
    check({tag, "_left"}, 32'(sb_q.size()), 0);
    check({tag, "_empty"}, 32'(fifo_level), 0);
  endtask

  function automatic logic [31:0] oeb4();
    return 32'({io_reset_n_oeb, io_latch_data_oeb, io_control_trigger_oeb, io_update_cycle_complete_oeb});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int rises;

    reset_n               = 1'b0;
    la_data_in            = '0;
    la_oenb               = '1;
    io_reset_n_in         = 1'b0;
    io_latch_data_in      = 1'b0;
    io_control_trigger_in = 1'b0;
    update_cycle_complete = 1'b0;
    spi_data_clock        = 1'b0;
    spi_data              = '0;
    cmd_ready             = 1'b0;

    step(2);
    check("rst_oeb", oeb4(), 32'hF);
    check("rst_drv", 32'(io_driver_io_oeb), 32'(10'h3FF));
    check("rst_core", 32'(core_reset_n), 0);
    check("rst_fifo", {cmd_data[30:0] | 31'(fifo_level), cmd_valid | fifo_overflow}, 0);
    check("rst_filt", 32'({latch_data_s, control_trigger_s, latch_data_rise}), 0);

    reset_n = 1'b1;
    step(1);
    check("mux_oeb_default", oeb4(), 32'hE);
    check("mux_drv_default", 32'(io_driver_io_oeb), 0);
    update_cycle_complete         = 1'b1;
    la_oenb[LA_DRV_OEB_BASE]      = 1'b0;
    la_data_in[LA_DRV_OEB_BASE]   = 1'b1;
    la_oenb[LA_UCC_OEB]           = 1'b0;
    la_data_in[LA_UCC_OEB]        = 1'b1;
    step(1);
    check("ucc_out_pad", 32'(io_update_cycle_complete_out), 1);
    check("drv_la", 32'(io_driver_io_oeb), 1);
    check("ucc_oeb_la", oeb4(), 32'hF);
    la_oenb = '1;
    la_data_in = '0;
    step(FILTER_LEN + 1);
    check("core_held_low", 32'(core_reset_n), 0);

    io_reset_n_in = 1'b1;
    step(3);
    check("core_release_early", 32'(core_reset_n), 0);
    step(1);
    check("core_release", 32'(core_reset_n), 1);

    la_oenb[LA_LATCH]    = 1'b0;
    la_data_in[LA_LATCH] = 1'b1;
    step(FILTER_LEN + 2);
    check("latch_la_early", 32'(latch_data_s), 0);
    step(1);
    check("latch_la_set", 32'(latch_data_s), 1);
    check("latch_rise", 32'(latch_data_rise), 1);
    step(1);
    check("latch_rise_once", 32'(latch_data_rise), 0);
    check("latch_la_hold", 32'(latch_data_s), 1);
    la_oenb[LA_LATCH]    = 1'b1;
    la_data_in[LA_LATCH] = 1'b0;
    step(FILTER_LEN + 3);
    check("latch_la_clear", 32'(latch_data_s), 0);

    io_latch_data_in = 1'b1;
    step(2);
    io_latch_data_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (latch_data_s) seen++;
    end
    check("latch_glitch_reject", 32'(seen), 0);
    io_latch_data_in = 1'b1;
    step(3);
    io_latch_data_in = 1'b0;
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (latch_data_rise) rises++;
    end
    check("latch_pulse3_rises", 32'(rises), 1);

    io_control_trigger_in = 1'b1;
    step(FILTER_LEN + 2);
    check("trig_early", 32'(control_trigger_s), 0);
    step(1);
    check("trig_set", 32'(control_trigger_s), 1);
    io_control_trigger_in = 1'b0;
    step(FILTER_LEN + 3);
    check("trig_clear", 32'(control_trigger_s), 0);

    for (int i = 1; i <= 4; i++) send_word(32'hA5A50000 + 32'(i), 1'b1);
    check("fill_level", 32'(fifo_level), 4);
    check("fill_no_ovf", 32'(fifo_overflow), 0);
    check("fill_head", cmd_data, 32'hA5A50001);
    send_word(32'hDEAD0005, 1'b0);
    check("ovf_set", 32'(fifo_overflow), 1);
    check("ovf_level", 32'(fifo_level), 4);
    drain("drain1");
    check("ovf_sticky", 32'(fifo_overflow), 1);

    send_word(32'h11110001, 1'b1);
    send_word(32'h11110002, 1'b1);
    check("pre_flush_level", 32'(fifo_level), 2);
    io_reset_n_in = 1'b0;
    step(FILTER_LEN + 2);
    check("core_assert_early", 32'(core_reset_n), 1);
    step(1);
    check("core_assert", 32'(core_reset_n), 0);
    io_reset_n_in = 1'b1;
    step(1);
    sb_q.delete();
    check("flush_level", 32'(fifo_level), 0);
    check("flush_ovf", 32'(fifo_overflow), 0);
    step(3);
    check("core_reup", 32'(core_reset_n), 1);

    for (int i = 1; i <= 4; i++) send_word(32'hB0B00000 + 32'(i), 1'b1);
    spi_data       = 32'hB0B00005;
    spi_data_clock = ~spi_data_clock;
    step(2);
    cmd_ready = 1'b1;
    check("pp_head", cmd_data, sb_q.pop_front());
    sb_q.push_back(32'hB0B00005);
    step(1);
    cmd_ready = 1'b0;
    check("pp_level", 32'(fifo_level), 4);
    check("pp_no_ovf", 32'(fifo_overflow), 0);
    step(2);
    drain("drain2");

    send_word(32'hC0C00001, 1'b1);
    spi_data       = 32'hC0C00002;
    spi_data_clock = ~spi_data_clock;
    step(1);
    #3 reset_n = 1'b0;
    #1;
    sb_q.delete();
    check("async_level", 32'(fifo_level), 0);
    check("async_valid", {cmd_data[30:0], cmd_valid}, 0);
    check("async_core", 32'(core_reset_n), 0);
    check("async_oeb", oeb4(), 32'hF);
    step(1);
    reset_n = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controller_frontend.md
Name: controller_frontend

Overview:
- Parametrised IO front-end for the controller; sits between the user pads/logic analyser and system_controller.
- Registers the LA override muxes for pad OEBs and control inputs.
- Synchronises and hysteresis-filters reset, latch and trigger.
- Captures SPI command words signalled by a toggle on spi_data_clock and queues them in a FIFO.
- Presents the queue to system_controller with a valid/ready handshake.

Parameters:
- NUM_OF_DRIVERS, 10, number of driver IO OEBs controllable from the LA.
- CMD_WIDTH, 32, SPI command word width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- FILTER_LEN, 3, consecutive agreeing synchronised samples needed to change a filtered level; at least 1.

Ports:
- clock  in  1  system clock; every flop is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- la_data_in  in  8+NUM_OF_DRIVERS  LA override values.
- la_oenb  in  8+NUM_OF_DRIVERS  LA override enables, active-low per bit.
- io_reset_n_in / io_latch_data_in / io_control_trigger_in  in  1 each  raw pad inputs.
- update_cycle_complete  in  1  from backend_cycle_controller.
- spi_data_clock  in  1  asynchronous word toggle; each edge announces a new word.
- spi_data  in  CMD_WIDTH  word; held stable at least 4 clock cycles after its toggle.
- cmd_ready  in  1  consumer accepts head word.
- io_reset_n_oeb / io_latch_data_oeb / io_control_trigger_oeb / io_update_cycle_complete_oeb  out  1 each.
- io_update_cycle_complete_out  out  1.
- io_driver_io_oeb  out  NUM_OF_DRIVERS.
- core_reset_n  out  1  filtered functional reset for the controller.
- latch_data_s / control_trigger_s  out  1 each  filtered levels.
- latch_data_rise  out  1  one-cycle pulse on latch_data_s rising.
- cmd_data  out  CMD_WIDTH  FIFO head; cmd_valid  out  1  FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- fifo_overflow  out  1  sticky word-dropped flag.

Behaviour:
- Reset (reset_n low, async):
  - All *_oeb outputs = 1, including every io_driver_io_oeb bit.
  - io_update_cycle_complete_out = 0, core_reset_n = 0.
  - latch_data_s, control_trigger_s, latch_data_rise = 0.
  - FIFO empty: cmd_valid = 0, fifo_level = 0, fifo_overflow = 0, cmd_data = 0.
  - Synchroniser and filter flops = 0, except the reset path, which resets to 0 so core_reset_n deasserts only after sampling 1.
- LA mux, registered, 1 cycle:
  - OEB bits 0..3 = la_oenb[i] ? default : la_data_in[i]. Defaults: 1, 1, 1, 0.
  - Bits 4..6 select the raw reset/latch/trigger: LA value or pad.
  - Bit 7 selects io_update_cycle_complete_out: LA value or update_cycle_complete.
  - Bits 8+i drive io_driver_io_oeb[i], default 0.
- Synchronise: two-flop synchroniser on the three muxed raw inputs and on spi_data_clock.
- Filter on latch and trigger:
  - Output goes to 1 when the last FILTER_LEN synchronised samples are all 1.
  - Output goes to 0 when they are all 0; otherwise it holds (hysteresis).
  - A pad change set up before edge 1 is visible after edge 3+FILTER_LEN.
- Filter on reset:
  - core_reset_n asserts (0) only after FILTER_LEN consecutive 0 samples.
  - It deasserts on the first synchronised 1.
- latch_data_rise: high for exactly one cycle, coincident with the first cycle latch_data_s = 1.
- SPI capture:
  - A mismatch between synchronised toggle and its delayed copy is a capture event, 3 edges after the toggle.
  - spi_data is written to the FIFO tail at that edge.
  - Two toggles closer than 4 cycles violate the protocol; no detection is required.
- FIFO, show-ahead:
  - cmd_data = head, cmd_valid = (level != 0).
  - Pop when cmd_valid && cmd_ready.
  - Push to empty: cmd_valid rises the next cycle; no fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full with push and no pop: word dropped, fifo_overflow set, level stays FIFO_DEPTH.
  - Full with push and pop: both occur, level unchanged, no overflow.
  - Empty with cmd_ready: no effect.
- core_reset_n low (filtered): synchronously flush the FIFO and clear fifo_overflow. Capture events during this time are discarded.

Decomposition:
- Package controller_pkg holds:
  - LA bit-index constants: LA_RESET_OEB=0, LA_LATCH_OEB=1, LA_TRIG_OEB=2, LA_UCC_OEB=3, LA_RESET=4, LA_LATCH=5, LA_TRIG=6, LA_UCC=7, LA_DRV_OEB_BASE=8.
  - OEB default values.
- One sub-module, cmd_fifo: synchronous show-ahead FIFO with flush, overflow flag and level output, parametrised by width and depth.

Test Plan:
- Reset, then la_oenb all 1 and all pads 0 → after 1 cycle: OEBs = 1,1,1,0; io_driver_io_oeb = 0; core_reset_n = 0 after FILTER_LEN+3 cycles.
- Set la_oenb[5]=0, la_data_in[5]=1 → latch_data_s = 1 exactly 6 edges later (FILTER_LEN=3); latch_data_rise high for that single cycle.
- Pad latch high for 2 cycles, then low → latch_data_s stays 0; high for 3 or more cycles → rises.
- Toggle spi_data_clock 4 times with words 0xA5A50001..0xA5A50004, cmd_ready=0 → fifo_level=4; a 5th word 0xDEAD0005 sets fifo_overflow; draining yields words 1..4 in order.
- FIFO full, then a push and a pop on the same edge → level stays 4, no overflow, new word at the tail.
- Drive reset pad low for FILTER_LEN+3 cycles with the FIFO holding 2 words → FIFO flushed, fifo_overflow cleared; async reset_n mid-push → everything returns to reset values immediately.
